// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if: frame-start / read-strobe bundle for conv_window_ctrl; stall exists only with CONV_CTRL_STALL_EN
interface conv_window_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
`ifdef CONV_CTRL_STALL_EN
    logic                  stall;
`endif
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  window_valid;
    logic                  row_end;
    logic                  busy;
    logic                  done;
`ifdef CONV_CTRL_STALL_EN
    modport master (output start, stall, input rd_en, rd_addr, window_valid, row_end, busy, done);
    modport slave  (input start, stall, output rd_en, rd_addr, window_valid, row_end, busy, done);
`else
    modport master (output start, input rd_en, rd_addr, window_valid, row_end, busy, done);
    modport slave  (input start, output rd_en, rd_addr, window_valid, row_end, busy, done);
`endif
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: raster-scan read sequencer flagging completed KxK windows; CONV_CTRL_STALL_EN adds a scan-freezing stall input
module conv_window_ctrl #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int K          = 5,
    parameter int ADDR_WIDTH = 10
) (
    input logic             clk,
    input logic             reset,
    conv_window_ctrl_if.slave bus
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(IMG_W * IMG_H - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  rd_en_q, wv_q, row_end_q, busy_q, done_q, stall_w;
`ifdef CONV_CTRL_STALL_EN
    assign stall_w = bus.stall;
`else
    assign stall_w = 1'b0;
`endif
    always_comb begin
        addr_d = addr_q + 1'b1;
        col_d  = (col_q == CW'(IMG_W - 1)) ? '0 : col_q + 1'b1;
        row_d  = (col_q == CW'(IMG_W - 1)) ? row_q + 1'b1 : row_q;
    end
    // Outputs are registered alongside the counters so they describe the pixel addressed this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            rd_en_q   <= 1'b0;
            wv_q      <= 1'b0;
            row_end_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q   <= RUN;
                    addr_q    <= '0;
                    col_q     <= '0;
                    row_q     <= '0;
                    rd_en_q   <= 1'b1;
                    busy_q    <= 1'b1;
                    row_end_q <= (IMG_W == 1);
                    wv_q      <= (K == 1);
                end
                RUN: if (stall_w) begin
                    rd_en_q   <= 1'b0;
                    wv_q      <= 1'b0;
                    row_end_q <= 1'b0;
                end else if (addr_q == LAST) begin
                    state_q   <= DONE;
                    rd_en_q   <= 1'b0;
                    wv_q      <= 1'b0;
                    row_end_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                end else begin
                    addr_q    <= addr_d;
                    col_q     <= col_d;
                    row_q     <= row_d;
                    rd_en_q   <= 1'b1;
                    row_end_q <= (col_d == CW'(IMG_W - 1));
                    wv_q      <= (int'(col_d) >= K - 1) && (int'(row_d) >= K - 1);
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.rd_en        = rd_en_q;
    assign bus.rd_addr      = addr_q;
    assign bus.window_valid = wv_q;
    assign bus.row_end      = row_end_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: randomized self-checking bench against a pixel-index reference model
module tb_conv_window_ctrl;
    localparam int W = 32, H = 32, KK = 5, AW = 10, N = W * H;
    localparam int VW = AW + 5;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall_s = 1'b0;
    int   checks = 0;
    int   errors = 0;
    conv_window_ctrl_if #(.ADDR_WIDTH(AW)) b();
    conv_window_ctrl_if #(.ADDR_WIDTH(5))  bs();
    conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK), .ADDR_WIDTH(AW)) u_dut (
        .clk(clk), .reset(reset), .bus(b.slave));
    conv_window_ctrl #(.IMG_W(5), .IMG_H(5), .K(5), .ADDR_WIDTH(5)) u_small (
        .clk(clk), .reset(reset), .bus(bs.slave));
`ifdef CONV_CTRL_STALL_EN
    assign b.stall  = stall_s;
    assign bs.stall = 1'b0;
`endif
    always #5 clk = ~clk;
    // Reference: a frame is pixel index m_p walking 0..N-1; col/row derived arithmetically
    logic m_run = 1'b0, m_done = 1'b0, m_rd = 1'b0;
    int   m_p = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run <= 1'b0; m_done <= 1'b0; m_rd <= 1'b0; m_p <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_run) begin
            if (stall_s) m_rd <= 1'b0;
            else if (m_p == N - 1) begin
                m_run <= 1'b0; m_done <= 1'b1; m_rd <= 1'b0;
            end else begin
                m_p <= m_p + 1; m_rd <= 1'b1;
            end
        end else if (b.start) begin
            m_run <= 1'b1; m_p <= 0; m_rd <= 1'b1;
        end
    end
    function automatic logic [VW-1:0] exp_vec();
        int   col = m_p % W;
        int   row = m_p / W;
        logic re  = m_run && m_rd;
        return {re, AW'(m_p), re && col >= KK - 1 && row >= KK - 1, re && col == W - 1, m_run, m_done};
    endfunction
    function automatic logic [VW-1:0] dut_vec();
        return {b.rd_en, b.rd_addr, b.window_valid, b.row_end, b.busy, b.done};
    endfunction
    task automatic test_reset();
        @(negedge clk);
        if (dut_vec() !== '0) begin errors++; $display("FAIL reset_main got %h exp 0", dut_vec()); end
        checks++;
        if ({bs.rd_en, bs.rd_addr, bs.window_valid, bs.row_end, bs.busy, bs.done} !== '0) begin
            errors++; $display("FAIL reset_small got rd_en=%b addr=%0d", bs.rd_en, bs.rd_addr);
        end
        checks++;
        reset = 1'b0;
    endtask
    task automatic test_frame();
        int wv_n = 0, re_n = 0, rd_n = 0, done_n = 0, first = -1, done_at = -1;
        for (int c = 0; c < 1030; c++) begin
            @(negedge clk);
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL frame c=%0d got %h exp %h", c, dut_vec(), exp_vec()); end
            checks++;
            if (b.window_valid) begin wv_n++; if (first < 0) first = int'(b.rd_addr); end
            if (b.row_end) re_n++;
            if (b.rd_en) rd_n++;
            if (b.done) begin done_n++; done_at = c; end
            b.start = (c == 0);
        end
        if (wv_n != 784) begin errors++; $display("FAIL frame_windows got %0d exp 784", wv_n); end
        if (first != 132) begin errors++; $display("FAIL frame_first_window got %0d exp 132", first); end
        if (re_n != 32) begin errors++; $display("FAIL frame_row_end got %0d exp 32", re_n); end
        if (rd_n != 1024) begin errors++; $display("FAIL frame_reads got %0d exp 1024", rd_n); end
        if (done_n != 1 || done_at != 1025) begin errors++; $display("FAIL frame_done got n=%0d at %0d exp 1 at 1025", done_n, done_at); end
        checks += 5;
    endtask
    task automatic test_ignore_start();
        int done_n = 0, done_at = -1;
        for (int c = 0; c < 1030; c++) begin
            @(negedge clk);
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL ignore c=%0d got %h exp %h", c, dut_vec(), exp_vec()); end
            checks++;
            if (b.done) begin done_n++; done_at = c; end
            if (c == 1027) begin
                if (!(b.rd_en === 1'b1 && b.rd_addr === '0)) begin
                    errors++; $display("FAIL b2b_restart got rd_en=%b addr=%0d exp 1 0", b.rd_en, b.rd_addr);
                end
                checks++;
            end
            b.start = (c == 0 || c == 500 || c == 1026) || (c > 1 && c < 1020 && $urandom_range(0, 15) == 0);
        end
        if (done_n != 1 || done_at != 1025) begin errors++; $display("FAIL ignore_done got n=%0d at %0d exp 1 at 1025", done_n, done_at); end
        checks++;
        b.start = 1'b0;
        for (int c = 0; c < 1100 && (b.busy || b.done); c++) begin
            @(negedge clk);
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL ignore_drain c=%0d got %h exp %h", c, dut_vec(), exp_vec()); end
            checks++;
        end
    endtask
    task automatic test_reset_midframe();
        int done_n = 0;
        for (int c = 0; c < 301; c++) begin
            @(negedge clk);
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL midrst c=%0d got %h exp %h", c, dut_vec(), exp_vec()); end
            checks++;
            b.start = (c == 0);
        end
        reset = 1'b1;
        #1;
        if (dut_vec() !== '0) begin errors++; $display("FAIL midrst_async got %h exp 0", dut_vec()); end
        checks++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL midrst_after c=%0d got %h exp %h", c, dut_vec(), exp_vec()); end
            checks++;
            if (b.done) done_n++;
        end
        if (done_n != 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", done_n); end
        checks++;
        b.start = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
        if (!(b.rd_en === 1'b1 && b.rd_addr === '0)) begin errors++; $display("FAIL midrst_restart got rd_en=%b addr=%0d exp 1 0", b.rd_en, b.rd_addr); end
        checks++;
        for (int c = 0; c < 1100 && (b.busy || b.done); c++) begin
            @(negedge clk);
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL midrst_drain c=%0d got %h exp %h", c, dut_vec(), exp_vec()); end
            checks++;
        end
    endtask
    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL random c=%0d got %h exp %h", c, dut_vec(), exp_vec()); end
            checks++;
            b.start = ($urandom_range(0, 63) == 0);
`ifdef CONV_CTRL_STALL_EN
            stall_s = ($urandom_range(0, 3) == 0);
`endif
        end
        b.start = 1'b0;
        stall_s = 1'b0;
        for (int c = 0; c < 1100 && (b.busy || b.done); c++) begin
            @(negedge clk);
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL random_drain c=%0d got %h exp %h", c, dut_vec(), exp_vec()); end
            checks++;
        end
    endtask
`ifdef CONV_CTRL_STALL_EN
    task automatic test_stall();
        int done_at = -1;
        for (int c = 0; c < 1035; c++) begin
            @(negedge clk);
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL stall c=%0d got %h exp %h", c, dut_vec(), exp_vec()); end
            checks++;
            if (b.done) done_at = c;
            if (c == 12) begin
                if (!(b.rd_en === 1'b0 && b.rd_addr === AW'(9) && b.busy === 1'b1)) begin
                    errors++; $display("FAIL stall_hold got rd_en=%b addr=%0d exp 0 9", b.rd_en, b.rd_addr);
                end
                checks++;
            end
            if (c == 16) begin
                if (!(b.rd_en === 1'b1 && b.rd_addr === AW'(10))) begin
                    errors++; $display("FAIL stall_resume got rd_en=%b addr=%0d exp 1 10", b.rd_en, b.rd_addr);
                end
                checks++;
            end
            b.start = (c == 0);
            stall_s = (c >= 10 && c <= 14);
        end
        if (done_at != 1030) begin errors++; $display("FAIL stall_done got %0d exp 1030", done_at); end
        checks++;
    endtask
`endif
    task automatic test_small();
        int wv_n = 0, wv_addr = -1, wv_at = -1, wv_re = 0, done_at = -1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (bs.window_valid) begin wv_n++; wv_addr = int'(bs.rd_addr); wv_at = c; wv_re = int'(bs.row_end); end
            if (bs.done) done_at = c;
            bs.start = (c == 0);
        end
        if (wv_n != 1 || wv_addr != 24) begin errors++; $display("FAIL small_window got n=%0d addr=%0d exp 1 24", wv_n, wv_addr); end
        if (wv_re != 1) begin errors++; $display("FAIL small_row_end got %0d exp 1", wv_re); end
        if (done_at != 26 || done_at != wv_at + 1) begin errors++; $display("FAIL small_done got %0d exp 26", done_at); end
        checks += 3;
    endtask
    initial begin
        b.start  = 1'b0;
        bs.start = 1'b0;
        test_reset();
        test_frame();
        test_ignore_start();
        test_reset_midframe();
        test_random();
`ifdef CONV_CTRL_STALL_EN
        test_stall();
`endif
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 32, meaning input feature-map width in pixels.
REQ-002 SHALL have parameter IMG_H, default 32, meaning input feature-map height in pixels.
REQ-003 SHALL have parameter K, default 5, meaning square kernel size.
REQ-004 SHALL have parameter ADDR_WIDTH, default 10, meaning read-address width; IMG_W*IMG_H <= 2^ADDR_WIDTH.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle frame start request.
REQ-008 SHALL have port stall, input, 1, freezes the scan while high (present only with CONV_CTRL_STALL_EN).
REQ-009 SHALL have port rd_en, output, 1, feature-map memory read strobe.
REQ-010 SHALL have port rd_addr, output, ADDR_WIDTH, raster-order pixel read address.
REQ-011 SHALL have port window_valid, output, 1, the pixel read this cycle completes a KxK window; consumed by the downstream 3-cycle valid delay line.
REQ-012 SHALL have port row_end, output, 1, the pixel read this cycle is the last column of its row.
REQ-013 SHALL have port busy, output, 1, frame scan in progress.
REQ-014 SHALL have port done, output, 1, one-cycle frame-complete pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE: start=1 -> RUN next cycle; start=0 -> stay; rd_en=0, busy=0, done=0.
REQ-017 SHALL, on the first RUN cycle, assert rd_en=1 with rd_addr=0, col=0, row=0, busy=1.
REQ-018 SHALL, on each non-stalled RUN cycle, increment rd_addr by 1 and col by 1; col=IMG_W-1 wraps to 0 and increments row.
REQ-019 SHALL assert row_end exactly when col=IMG_W-1 in the same cycle as that rd_en.
REQ-020 SHALL assert window_valid exactly when rd_en=1, col>=K-1 and row>=K-1, giving (IMG_W-K+1)*(IMG_H-K+1) pulses per frame.
REQ-021 SHALL, after issuing rd_addr=IMG_W*IMG_H-1, enter DONE: rd_en=0, window_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-022 SHALL ignore start while in RUN or DONE; no restart, no counter disturbance.
REQ-023 SHALL accept start in the IDLE cycle that immediately follows DONE (back-to-back frames, 1-cycle gap).
REQ-024 Latency: start at cycle n -> first rd_en at n+1 -> done at n+1+IMG_W*IMG_H (no stall).
REQ-025 rd_addr, col, row SHALL be reset to 0 on entry to RUN; rd_addr holds its last value outside RUN.

Reset
REQ-026 reset=1 SHALL asynchronously force state=IDLE, rd_en=0, rd_addr=0, window_valid=0, row_end=0, busy=0, done=0, col=row=0.
REQ-027 reset asserted mid-frame SHALL abort the frame with no done pulse; first rising edge after release operates from IDLE.

Configuration
REQ-028 Macro CONV_CTRL_STALL_EN defined: stall port exists; stall=1 in RUN SHALL hold rd_addr/col/row, force rd_en=0, window_valid=0, row_end=0, keep busy=1; scan resumes at the held address when stall=0; stall ignored in IDLE/DONE.
REQ-029 Macro CONV_CTRL_STALL_EN undefined: no stall port; RUN never pauses.

Verification
REQ-030 Defaults, start at cycle 0 -> rd_en high cycles 1..1024, rd_addr 0..1023, done at cycle 1025 only.
REQ-031 Defaults, full frame -> exactly 784 window_valid pulses, first at rd_addr=132 (row 4, col 4), 32 row_end pulses.
REQ-032 start pulsed at cycles 0 and 500 -> second start ignored, single done at 1025; start at 1026 -> new frame, rd_addr=0 at 1027.
REQ-033 reset asserted at cycle 300 for 2 cycles -> all outputs 0 immediately, no done; new start -> rd_addr restarts at 0.
REQ-034 With CONV_CTRL_STALL_EN, stall high cycles 10..14 -> rd_en=0 those cycles, rd_addr held at 9 then 10 next, done at 1030.
REQ-035 IMG_W=IMG_H=K=5 -> single window_valid at rd_addr=24 coincident with row_end, done one cycle later.
